// File: rtl/div_pkg.sv
// div_pkg: shared state encodings and sizing helper for sequential arithmetic blocks
package div_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  typedef enum logic [1:0] {ST_IDLE = IDLE, ST_CALC = CALC, ST_DONE = DONE} state_e;
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: request/result bundle of div_seq; div_zero exists only with DIV_SEQ_ZERO_FLAG_EN
interface div_seq_if #(parameter int N = 8);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
`ifdef DIV_SEQ_ZERO_FLAG_EN
  logic         div_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_zero);
`else
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder);
`endif
endinterface

// File: rtl/div_step.sv
// div_step: one restoring step -- shift in a dividend bit, trial-subtract, keep or restore
module div_step #(parameter int N = 8) (
  input  logic [N-1:0] rem_i,
  input  logic         bit_i,
  input  logic [N-1:0] div_i,
  output logic [N-1:0] rem_o,
  output logic         q_o
);
  logic [N:0] sh, trial;
  assign sh    = {rem_i, bit_i};
  assign trial = sh - {1'b0, div_i};
  assign q_o   = sh >= {1'b0, div_i};
  assign rem_o = q_o ? trial[N-1:0] : sh[N-1:0];
endmodule

// File: rtl/div_seq.sv
// div_seq: N-step restoring unsigned divider; DIV_SEQ_ZERO_FLAG_EN adds a fast zero-divisor path with div_zero
module div_seq import div_pkg::*; #(parameter int N = 8) (
  input logic     clk,
  input logic     rst_n,
  div_seq_if.slave bus
);
  localparam int CW = cnt_w(N);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d, res_q, res_d;
  logic [N-1:0]  step_rem;
  logic          step_q, zero, last;
`ifdef DIV_SEQ_ZERO_FLAG_EN
  logic          dz_q, dz_d;
  assign zero = dvs_q == '0;
  assign bus.div_zero = dz_q;
`else
  assign zero = 1'b0;
`endif
  assign last      = zero || cnt_q == CW'(N - 1);
  assign bus.busy  = state_q == ST_CALC;
  assign bus.done  = state_q == ST_DONE;
  assign bus.quotient  = quo_q;
  assign bus.remainder = res_q;
  div_step #(.N(N)) u_step (.rem_i(rem_q), .bit_i(dvd_q[N-1]), .div_i(dvs_q), .rem_o(step_rem), .q_o(step_q));
  // next state: accept in IDLE, one step per edge in CALC (quotient bits shift into the dividend register), one-cycle DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
`ifdef DIV_SEQ_ZERO_FLAG_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d = ST_CALC;
        dvd_d   = bus.dividend;
        dvs_d   = bus.divisor;
        rem_d   = '0;
        cnt_d   = '0;
      end
      ST_CALC: begin
        dvd_d = {dvd_q[N-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = ST_DONE;
          quo_d   = zero ? '1 : {dvd_q[N-2:0], step_q};
          res_d   = zero ? dvd_q : step_rem;
`ifdef DIV_SEQ_ZERO_FLAG_EN
          dz_d    = zero;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state and datapath registers, all cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
`ifdef DIV_SEQ_ZERO_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
`ifdef DIV_SEQ_ZERO_FLAG_EN
      dz_q    <= dz_d;
`endif
    end
  end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter N, default 8, operand, quotient and remainder width in bits (N >= 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  the single reset: asynchronous, active-low.
REQ-004 start  input  1  request to begin a division; sampled only while idle.
REQ-005 dividend  input  N  unsigned dividend, captured on the accepting edge.
REQ-006 divisor  input  N  unsigned divisor, captured on the accepting edge.
REQ-007 busy  output  1  high from the accepting edge until the edge that raises done.
REQ-008 done  output  1  one-cycle pulse; results valid while high.
REQ-009 quotient  output  N  unsigned quotient, registered.
REQ-010 remainder  output  N  unsigned remainder, registered.
REQ-011 div_zero  output  1  divisor-was-zero flag; present only when DIV_SEQ_ZERO_FLAG_EN is defined.

Function
REQ-012 The state machine SHALL have three states:
- IDLE: busy=0.
- CALC: busy=1.
- DONE: busy=0, done=1.
REQ-013 IDLE -> CALC on a rising edge with start=1:
- latch dividend and divisor;
- clear the partial remainder;
- clear the iteration counter;
- keep quotient and remainder outputs unchanged.
REQ-014 CALC SHALL run one restoring step per edge, MSB first:
- shift the partial remainder left one bit, bringing in the next dividend bit;
- trial-subtract divisor in N+1-bit arithmetic;
- if the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
REQ-015 After exactly N steps, CALC -> DONE:
- quotient and remainder are registered on that same edge;
- done is high for the following cycle, N+1 edges after the accepting edge.
REQ-016 DONE -> IDLE unconditionally on the next edge.
- done deasserts.
- quotient and remainder hold until the next completion or reset.
REQ-017 start SHALL be ignored while in CALC or DONE; the operation in progress is unaffected.
REQ-018 start=1 held continuously SHALL re-accept on the first edge in IDLE after DONE, i.e. back-to-back period N+2 edges.
REQ-019 Changes to dividend and divisor after the accepting edge SHALL NOT affect the result.
REQ-020 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every divisor != 0.
REQ-021 Without DIV_SEQ_ZERO_FLAG_EN, divisor=0 SHALL:
- run the full N steps;
- return quotient = all ones and remainder = dividend.

Reset
REQ-022 rst_n low SHALL immediately force:
- state IDLE;
- busy=0, done=0;
- quotient=0, remainder=0, div_zero=0 (if present);
- counter and working registers to 0.
REQ-023 Reset asserted mid-CALC SHALL abort the operation with no done pulse.
REQ-024 The first start after rst_n release is accepted on the first rising edge with start=1.

Configuration
REQ-025 With DIV_SEQ_ZERO_FLAG_EN defined, a zero divisor SHALL be detected on the accepting edge:
- go directly to DONE with busy high for one cycle;
- done high 2 edges after acceptance;
- quotient = all ones, remainder = dividend, div_zero=1.
REQ-026 With DIV_SEQ_ZERO_FLAG_EN defined, div_zero SHALL be 0 for every non-zero-divisor completion and SHALL hold its value with the results.
REQ-027 Without DIV_SEQ_ZERO_FLAG_EN, the div_zero port and its logic SHALL be absent and REQ-021 applies.

Structure
REQ-028 The following SHALL live in a shared package div_pkg, reused by future arithmetic blocks:
- state encodings IDLE/CALC/DONE as localparams;
- the counter-width function (clog2).
REQ-029 One combinational sub-module div_step SHALL implement a single shift/trial-subtract/restore step, instanced once inside div_seq.

Verification
REQ-030 The bench SHALL cover the following directed scenarios, all at N=8:
- 88/8, start for one cycle -> done on edge 9 after acceptance, quotient=11, remainder=0, busy high for exactly 8 cycles.
- 225/11 -> quotient=20, remainder=5; 255/1 -> 255, 0; 7/9 -> 0, 7.
- 132/12 accepted, then start pulsed with 50/5 during CALC -> single done, quotient=11, remainder=0; no second done.
- 125/0, with and without DIV_SEQ_ZERO_FLAG_EN:
  - defined: done 2 edges after acceptance, quotient=255, remainder=125, div_zero=1;
  - undefined: done after 9 edges, same values, no div_zero port.
- rst_n pulsed low at step 4 of 200/3 -> all outputs 0 immediately, no done; a new 200/3 then yields quotient=66, remainder=2.
